nes_ctrl_reader: RTL and testbench

Console-side initiator for the NES standard-controller serial protocol. It drives the latch and clock lines, samples the controller's active-low serial data, and presents an 8-bit active-high button vector with a one-cycle valid pulse. It sits between the board's controller-port pins (or `controller_sim` on the bench) and any logic that consumes button state, such as the cart `ctrl1_state` input or the frame-based stimulus logic. Reads run on demand, or periodically when auto-poll is enabled.

---
 rtl/nes_ctrl_reader_pkg.sv | 27 ++
 rtl/nes_ctrl_reader_if.sv | 21 ++
 rtl/nes_ctrl_reader_sync2.sv | 22 ++
 rtl/nes_ctrl_reader.sv | 167 ++++++++++++++++
 tb/tb_nes_ctrl_reader.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/nes_ctrl_reader_pkg.sv
// Shared constants and types for the NES controller reader.
// Button masks follow the serial shift order of a standard pad.
package nes_ctrl_pkg;

    localparam logic [7:0] BTN_A      = 8'h01;
    localparam logic [7:0] BTN_B      = 8'h02;
    localparam logic [7:0] BTN_SELECT = 8'h04;
    localparam logic [7:0] BTN_START  = 8'h08;
    localparam logic [7:0] BTN_UP     = 8'h10;
    localparam logic [7:0] BTN_DOWN   = 8'h20;
    localparam logic [7:0] BTN_LEFT   = 8'h40;
    localparam logic [7:0] BTN_RIGHT  = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CLK_LO = 3'd3,
        ST_CLK_HI = 3'd4,
        ST_DONE   = 3'd5
    } nes_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nes_ctrl_reader_if.sv
// Host handshake plus controller-port pins of the NES controller reader.
// slave is the reader itself; master is the host/pad side.
interface nes_ctrl_reader_if;
    logic       start;
    logic       ctrl_latch;
    logic       ctrl_clk;
    logic       ctrl_data;
    logic [7:0] btns;
    logic       btns_valid;
    logic       busy;

    modport master (
        output start, ctrl_data,
        input  ctrl_latch, ctrl_clk, btns, btns_valid, busy
    );

    modport slave (
        input  start, ctrl_data,
        output ctrl_latch, ctrl_clk, btns, btns_valid, busy
    );
endinterface

// File: rtl/nes_ctrl_reader_sync2.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/nes_ctrl_reader.sv
// NES standard-controller reader: drives latch/clock, shifts in 8 active-low
// bits and presents them active-high with a one-cycle valid pulse.
//
// state  | meaning
// IDLE   | waiting for start or auto-poll tick
// LATCH  | ctrl_latch high for LATCH_CYCLES
// SETTLE | latch released, bit 0 sampled in last cycle
// CLK_LO | ctrl_clk low half-period
// CLK_HI | ctrl_clk high half-period, bit k sampled in last cycle
// DONE   | btns updated, btns_valid pulsed
module nes_ctrl_reader
    import nes_ctrl_pkg::*;
#(
    parameter int LATCH_CYCLES = 12,
    parameter int HALF_CYCLES  = 6,
    parameter int POLL_PERIOD  = 0
) (
    input  logic             clk,
    input  logic             rst,
    nes_ctrl_reader_if.slave bus
);
    localparam int CW = $clog2(max_int(LATCH_CYCLES, HALF_CYCLES) + 1);
    localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LOAD  = CW'(HALF_CYCLES - 1);

    nes_state_e    state_q;
    logic [CW-1:0] phase_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic [7:0]    btns_q;
    logic          latch_q;
    logic          clk_q;
    logic          valid_q;
    logic          busy_q;
    logic          data_sync;
    logic          poll_tick;
    logic          trigger;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.ctrl_data),
        .q_o (data_sync)
    );

    generate
        if (POLL_PERIOD > 0) begin : g_poll
            localparam int PW = $clog2((POLL_PERIOD > 1) ? POLL_PERIOD : 2);
            localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
            logic [PW-1:0] poll_cnt_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    poll_cnt_q <= '0;
                end else if (poll_cnt_q == POLL_LAST) begin
                    poll_cnt_q <= '0;
                end else begin
                    poll_cnt_q <= poll_cnt_q + PW'(1);
                end
            end

            assign poll_tick = (poll_cnt_q == POLL_LAST);
        end else begin : g_no_poll
            assign poll_tick = 1'b0;
        end
    endgenerate

    // start and tick OR together, so a coincident pair is one read
    assign trigger = bus.start | poll_tick;

    // Controller data is active-low; store it inverted at the current bit slot
    always_comb begin
        shift_d            = shift_q;
        shift_d[bit_idx_q] = ~data_sync;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            btns_q    <= 8'h00;
            latch_q   <= 1'b0;
            clk_q     <= 1'b1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        state_q   <= ST_LATCH;
                        latch_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        phase_q   <= LATCH_LOAD;
                        bit_idx_q <= 3'd0;
                    end
                end
                ST_LATCH: begin
                    if (phase_q == '0) begin
                        state_q <= ST_SETTLE;
                        latch_q <= 1'b0;
                        phase_q <= HALF_LOAD;
                    end else begin
                        phase_q <= phase_q - CW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (phase_q == '0) begin
                        shift_q   <= shift_d;
                        bit_idx_q <= 3'd1;
                        state_q   <= ST_CLK_LO;
                        clk_q     <= 1'b0;
                        phase_q   <= HALF_LOAD;
                    end else begin
                        phase_q <= phase_q - CW'(1);
                    end
                end
                ST_CLK_LO: begin
                    if (phase_q == '0) begin
                        state_q <= ST_CLK_HI;
                        clk_q   <= 1'b1;
                        phase_q <= HALF_LOAD;
                    end else begin
                        phase_q <= phase_q - CW'(1);
                    end
                end
                ST_CLK_HI: begin
                    if (phase_q == '0) begin
                        shift_q <= shift_d;
                        if (bit_idx_q == 3'd7) begin
                            // Publish on entry so btns and valid land in DONE
                            state_q <= ST_DONE;
                            btns_q  <= shift_d;
                            valid_q <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            state_q   <= ST_CLK_LO;
                            clk_q     <= 1'b0;
                            phase_q   <= HALF_LOAD;
                        end
                    end else begin
                        phase_q <= phase_q - CW'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    latch_q <= 1'b0;
                    clk_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ctrl_latch = latch_q;
    assign bus.ctrl_clk   = clk_q;
    assign bus.btns       = btns_q;
    assign bus.btns_valid = valid_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_nes_ctrl_reader.sv
// Bench for nes_ctrl_reader: three instances (default timing, fast timing,
// auto-poll) each driven by a behavioural NES pad model.
module tb_nes_ctrl_reader;
    import nes_ctrl_pkg::*;

    logic       clk;
    logic       rst_s   [3];
    logic       start_s [3];
    logic [7:0] pat     [3];
    logic       lat     [3];
    logic       cck     [3];
    logic       bv      [3];
    logic       bsy     [3];
    logic [7:0] bt      [3];

    int n_chk  = 0;
    int n_pass = 0;

    nes_ctrl_reader_if ifs [3] ();

    nes_ctrl_reader #(.LATCH_CYCLES(12), .HALF_CYCLES(6), .POLL_PERIOD(0)) u_dut0 (
        .clk (clk), .rst (rst_s[0]), .bus (ifs[0]));
    nes_ctrl_reader #(.LATCH_CYCLES(4), .HALF_CYCLES(3), .POLL_PERIOD(0)) u_dut1 (
        .clk (clk), .rst (rst_s[1]), .bus (ifs[1]));
    nes_ctrl_reader #(.LATCH_CYCLES(12), .HALF_CYCLES(6), .POLL_PERIOD(200)) u_dut2 (
        .clk (clk), .rst (rst_s[2]), .bus (ifs[2]));

    // Pad model: latch loads the held buttons, each ctrl_clk rise shifts one out
    for (genvar i = 0; i < 3; i++) begin : g_pad
        logic [7:0] sr_l;
        always @(posedge ifs[i].ctrl_latch or posedge ifs[i].ctrl_clk) begin
            if (ifs[i].ctrl_latch) sr_l <= pat[i];
            else                   sr_l <= {1'b1, sr_l[7:1]};
        end
        assign ifs[i].ctrl_data = ~sr_l[0];
        assign ifs[i].start     = start_s[i];
        assign lat[i] = ifs[i].ctrl_latch;
        assign cck[i] = ifs[i].ctrl_clk;
        assign bv[i]  = ifs[i].btns_valid;
        assign bsy[i] = ifs[i].busy;
        assign bt[i]  = ifs[i].btns;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic exp_latch(input int c, input int l);
        return (c >= 1) && (c <= l);
    endfunction

    // ctrl_clk low during pulse k: cycles L+H(2k-1)+1 .. L+2kH
    function automatic logic exp_cclk(input int c, input int l, input int h);
        for (int k = 1; k <= 7; k++)
            if (c >= l + h*(2*k-1) + 1 && c <= l + 2*k*h) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_read(input int d, input int l, input int h,
                            input logic [7:0] pattern, input logic [7:0] exp,
                            input string nm);
        int t = l + 15*h + 1;
        int lat_err = 0, clk_err = 0, bsy_err = 0, vcnt = 0, vcyc = -1;
        logic [7:0] got = 8'h00;
        pat[d] = pattern;
        for (int c = 0; c <= t + 2; c++) begin
            start_s[d] = (c == 0);
            @(negedge clk);
            if (lat[d] !== exp_latch(c+1, l)) lat_err++;
            if (cck[d] !== exp_cclk(c+1, l, h)) clk_err++;
            if (bsy[d] !== ((c+1) <= t)) bsy_err++;
            if (bv[d] === 1'b1) begin
                vcnt++;
                vcyc = c + 1;
                got  = bt[d];
            end
        end
        start_s[d] = 1'b0;
        check({nm, "_latch_wave"}, lat_err, 0);
        check({nm, "_clk_wave"}, clk_err, 0);
        check({nm, "_busy_wave"}, bsy_err, 0);
        check({nm, "_valid_count"}, vcnt, 1);
        check({nm, "_valid_cycle"}, vcyc, t);
        check({nm, "_btns"}, int'(got), int'(exp));
        check({nm, "_btns_hold"}, int'(bt[d]), int'(exp));
    endtask

    typedef struct {
        int         dut;
        logic [7:0] pattern;
        logic [7:0] exp_btns;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int nv, prev, sim_cyc, vcnt, vcyc, late, found, nz;
        logic [7:0] cur, p;

        vecs[0] = '{0, BTN_START,           8'h08};
        vecs[1] = '{0, 8'h00,               8'h00};
        vecs[2] = '{0, 8'hFF,               8'hFF};
        vecs[3] = '{0, BTN_A | BTN_RIGHT,   8'h81};
        vecs[4] = '{1, 8'hA5,               8'hA5};
        vecs[5] = '{1, BTN_UP | BTN_LEFT,   8'h50};

        for (int i = 0; i < 3; i++) begin
            rst_s[i]   = 1'b1;
            start_s[i] = 1'b0;
            pat[i]     = 8'h00;
        end
        #2;
        for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset%0d_latch", i), int'(lat[i]), 0);
            check($sformatf("reset%0d_clk", i), int'(cck[i]), 1);
            check($sformatf("reset%0d_btns", i), int'(bt[i]), 0);
            check($sformatf("reset%0d_valid", i), int'(bv[i]), 0);
            check($sformatf("reset%0d_busy", i), int'(bsy[i]), 0);
        end
        rst_s[0] = 1'b1;
        rst_s[1] = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].dut == 0)
                run_read(0, 12, 6, vecs[i].pattern, vecs[i].exp_btns, $sformatf("vec%0d", i));
            else
                run_read(1, 4, 3, vecs[i].pattern, vecs[i].exp_btns, $sformatf("vec%0d", i));
        end

        // Expected result of any read is simply the pad state at latch time
        for (int i = 0; i < 6; i++) begin
            p = 8'($urandom_range(0, 255));
            run_read(1, 4, 3, p, p, $sformatf("rand%0d", i));
        end

        // start at cycles 0, 10 and T: only the first read happens
        pat[0] = BTN_B | BTN_DOWN;
        vcnt = 0; vcyc = -1; late = 0;
        for (int c = 0; c <= 103 + 40; c++) begin
            start_s[0] = (c == 0 || c == 10 || c == 103);
            @(negedge clk);
            if (bv[0] === 1'b1) begin
                vcnt++;
                vcyc = c + 1;
            end
            if (lat[0] === 1'b1 && (c + 1) > 12) late++;
        end
        start_s[0] = 1'b0;
        check("multi_start_valid_count", vcnt, 1);
        check("multi_start_valid_cycle", vcyc, 103);
        check("multi_start_no_relatch", late, 0);
        check("multi_start_btns", int'(bt[0]), 8'h22);

        // Reset while ctrl_clk is low
        pat[0] = 8'h5A;
        found  = 0;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (cck[0] === 1'b0) found = 1;
            else @(negedge clk);
        end
        check("rst_wait_clk_lo", found, 1);
        #2 rst_s[0] = 1'b0;
        #1;
        check("rst_mid_latch", int'(lat[0]), 0);
        check("rst_mid_clk", int'(cck[0]), 1);
        check("rst_mid_btns", int'(bt[0]), 0);
        check("rst_mid_valid", int'(bv[0]), 0);
        check("rst_mid_busy", int'(bsy[0]), 0);
        repeat (3) @(negedge clk);
        rst_s[0] = 1'b1;
        nv = 0; nz = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (bv[0] !== 1'b0) nv++;
            if (bt[0] !== 8'h00) nz++;
        end
        check("rst_after_no_valid", nv, 0);
        check("rst_after_btns_zero", nz, 0);

        // Auto-poll every 200 cycles; 4th poll coincides with a start pulse
        pat[2] = 8'h3C;
        cur = 8'h3C;
        nv = 0; prev = 0; sim_cyc = -1;
        @(negedge clk);
        rst_s[2] = 1'b1;
        for (int g = 0; g < 1300; g++) begin
            start_s[2] = (g == sim_cyc);
            @(negedge clk);
            if (bv[2] === 1'b1) begin
                nv++;
                check($sformatf("poll%0d_btns", nv), int'(bt[2]), int'(cur));
                if (nv > 1) check($sformatf("poll%0d_interval", nv), g + 1 - prev, 200);
                prev = g + 1;
                if (nv == 3) sim_cyc = g + 1 - 103 + 200;
                pat[2] = 8'($urandom_range(0, 255));
                cur = pat[2];
            end
        end
        start_s[2] = 1'b0;
        check("poll_valid_count", nv, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
